// File: rtl/axis_compressed_packer.sv
// rtl/axis_compressed_packer.sv - repacks variable-length compressed chunks into AXI-Stream beats
// Buffer index 0 is the oldest byte; bytes at or above fill are always kept zero.
module axis_compressed_packer #(
   parameter int IN_BYTES  = 16,
   parameter int OUT_BYTES = 8,
   parameter int BUF_BYTES = 32
) (
   input  logic                               dataOut_clk,
   input  logic                               dataOut_aresetn,
   input  logic [IN_BYTES*8-1:0]              csData,
   input  logic [$clog2(IN_BYTES+1)-1:0]      csByteCount,
   input  logic                               csValid,
   output logic                               csShift,
   input  logic                               endOfStream,
   output logic [OUT_BYTES*8-1:0]             dataOut_tdata,
   output logic                               dataOut_tvalid,
   output logic [OUT_BYTES-1:0]               dataOut_tstrb,
   output logic                               dataOut_tlast,
   input  logic                               dataOut_tready,
   output logic [$clog2(BUF_BYTES+1)-1:0]     fillLevel
);

   localparam int FILL_W = $clog2(BUF_BYTES+1);
   localparam logic [FILL_W-1:0] OUT_F     = FILL_W'(OUT_BYTES);
   localparam logic [FILL_W-1:0] SHIFT_LIM = FILL_W'(BUF_BYTES - IN_BYTES);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [BUF_BYTES*8-1:0] buf_q, buf_d;
   logic [FILL_W-1:0]      fill_q, fill_d;
   logic                   short_beat, push, pop;
   int                     pop_n, push_n, base;

   // Every output decodes registered state only, so nothing combinational reaches the port from inputs.
   always_comb begin
      short_beat     = fill_q < OUT_F;
      csShift        = (state_q == RUN) && (fill_q <= SHIFT_LIM);
      dataOut_tvalid = (state_q == FLUSH) || !short_beat;
      dataOut_tlast  = (state_q == FLUSH) && short_beat;
      dataOut_tdata  = buf_q[OUT_BYTES*8-1:0];
      fillLevel      = fill_q;
      dataOut_tstrb  = '0;
      for (int i = 0; i < OUT_BYTES; i++)
         dataOut_tstrb[i] = dataOut_tvalid && (!dataOut_tlast || (FILL_W'(i) < fill_q));
   end

   always_comb begin
      pop    = dataOut_tvalid && dataOut_tready;
      push   = csValid && csShift;
      pop_n  = 0;
      push_n = 0;
      if (pop)
         pop_n = short_beat ? int'(fill_q) : OUT_BYTES;
      if (push)
         push_n = (int'(csByteCount) > IN_BYTES) ? IN_BYTES : int'(csByteCount);
      base   = int'(fill_q) - pop_n;
      buf_d  = pop ? (buf_q >> (OUT_BYTES*8)) : buf_q;
      for (int i = 0; i < IN_BYTES; i++)
         if (i < push_n)
            buf_d[(base+i)*8 +: 8] = csData[i*8 +: 8];
      fill_d  = FILL_W'(base + push_n);
      state_d = state_q;
      if (state_q == RUN && endOfStream && csShift)
         state_d = FLUSH;
      if (state_q == FLUSH && pop && dataOut_tlast) begin
         state_d = RUN;
         fill_d  = '0;
         buf_d   = '0;
      end
   end

   always_ff @(posedge dataOut_clk or negedge dataOut_aresetn) begin
      if (!dataOut_aresetn) begin
         state_q <= RUN;
         buf_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         fill_q  <= fill_d;
      end
   end

endmodule

// File: tb/tb_axis_compressed_packer.sv
// tb/tb_axis_compressed_packer.sv - scoreboard bench for axis_compressed_packer
module tb_axis_compressed_packer;

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  s;
      logic        l;
   } beat_t;

   logic         clk = 0;
   logic         rst_n;
   logic [127:0] csData;
   logic [4:0]   csByteCount;
   logic         csValid, csShift, endOfStream;
   logic [63:0]  tdata;
   logic         tvalid, tlast, tready;
   logic [7:0]   tstrb;
   logic [5:0]   fillLevel;

   int           checks = 0;
   int           fails  = 0;
   int           mode   = 0;
   beat_t        exp_q[$];
   logic [7:0]   stream_q[$];
   logic         hold_v = 0;
   beat_t        hold_b;

   axis_compressed_packer dut (
      .dataOut_clk(clk), .dataOut_aresetn(rst_n),
      .csData(csData), .csByteCount(csByteCount), .csValid(csValid), .csShift(csShift),
      .endOfStream(endOfStream),
      .dataOut_tdata(tdata), .dataOut_tvalid(tvalid), .dataOut_tstrb(tstrb),
      .dataOut_tlast(tlast), .dataOut_tready(tready), .fillLevel(fillLevel)
   );

   always #5 clk = ~clk;

   initial begin
      tready = 0;
      forever begin
         @(posedge clk); #1;
         case (mode)
            0: tready = 1;
            1: tready = 0;
            default: tready = ~tready;
         endcase
      end
   end

   // Monitor: a beat is transferred at the next posedge when tvalid&&tready at the negedge.
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) hold_v = 0;
      else begin
         if (hold_v) begin
            checks++;
            if (!tvalid || tdata !== hold_b.d || tstrb !== hold_b.s || tlast !== hold_b.l) begin
               fails++;
               $display("FAIL stability: got v=%b %h/%h/%b required %h/%h/%b", tvalid, tdata, tstrb, tlast, hold_b.d, hold_b.s, hold_b.l);
            end
         end
         if (tvalid && tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_beat: got %h/%h/%b required none", tdata, tstrb, tlast);
            end else begin
               e = exp_q.pop_front();
               if (tdata !== e.d || tstrb !== e.s || tlast !== e.l) begin
                  fails++;
                  $display("FAIL beat: got %h/%h/%b required %h/%h/%b", tdata, tstrb, tlast, e.d, e.s, e.l);
               end
            end
            hold_v = 0;
         end else if (tvalid) begin
            hold_v = 1;
            hold_b = '{d: tdata, s: tstrb, l: tlast};
         end else hold_v = 0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Splits stream_q into full beats followed by one final partial or null tlast beat.
   task automatic expect_stream();
      int i = 0;
      logic [63:0] d;
      while (stream_q.size() - i >= 8) begin
         for (int k = 0; k < 8; k++) d[k*8 +: 8] = stream_q[i+k];
         exp_q.push_back('{d: d, s: 8'hFF, l: 1'b0});
         i += 8;
      end
      d = '0;
      for (int k = 0; k < stream_q.size() - i; k++) d[k*8 +: 8] = stream_q[i+k];
      exp_q.push_back('{d: d, s: 8'((1 << (stream_q.size() - i)) - 1), l: 1'b1});
   endtask

   task automatic send_chunk(input logic [127:0] d, input int n, input bit v, input bit eos);
      int t = 0;
      csData = d; csByteCount = 5'(n); csValid = v; endOfStream = eos;
      @(negedge clk);
      while (!csShift && t < 2000) begin @(negedge clk); t++; end
      if (!csShift) begin
         checks++; fails++;
         $display("FAIL send_timeout: got csShift=0 required 1");
      end
      @(posedge clk); #1;
      csValid = 0; endOfStream = 0; csData = '0; csByteCount = '0;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 1000) begin @(negedge clk); t++; end
      chk(name, 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sizes[10] = '{5, 16, 0, 7, 13, 1, 16, 9, 3, 12};
      int off;
      logic [127:0] d;
      rst_n = 0; csData = '0; csByteCount = '0; csValid = 0; endOfStream = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_csShift", 64'(csShift), 64'd1);
      chk("rst_fill", 64'(fillLevel), 64'd0);
      chk("rst_tdata", tdata, 64'd0);
      chk("rst_tstrb", 64'(tstrb), 64'd0);
      chk("rst_tlast", 64'(tlast), 64'd0);
      rst_n = 1;
      @(posedge clk); #1;

      // Two 16-byte chunks, then EOS alone
      exp_q.push_back('{d: 64'h0706050403020100, s: 8'hFF, l: 1'b0});
      exp_q.push_back('{d: 64'h0F0E0D0C0B0A0908, s: 8'hFF, l: 1'b0});
      exp_q.push_back('{d: 64'h1716151413121110, s: 8'hFF, l: 1'b0});
      exp_q.push_back('{d: 64'h1F1E1D1C1B1A1918, s: 8'hFF, l: 1'b0});
      exp_q.push_back('{d: 64'h0, s: 8'h00, l: 1'b1});
      send_chunk(128'h0F0E0D0C0B0A09080706050403020100, 16, 1, 0);
      send_chunk(128'h1F1E1D1C1B1A19181716151413121110, 16, 1, 0);
      send_chunk('0, 0, 0, 1);
      wait_drain("drain_t1");

      // 3 + 5 + 6 bytes with EOS on the last chunk
      exp_q.push_back('{d: 64'h0807060504030201, s: 8'hFF, l: 1'b0});
      exp_q.push_back('{d: 64'h00000E0D0C0B0A09, s: 8'h3F, l: 1'b1});
      send_chunk(128'h030201, 3, 1, 0);
      send_chunk(128'h0807060504, 5, 1, 0);
      send_chunk(128'h0E0D0C0B0A09, 6, 1, 1);
      wait_drain("drain_t2");

      // Backpressure: buffer fills to 32 and csShift drops
      mode = 1;
      @(posedge clk); #1;
      stream_q.delete();
      for (int k = 0; k < 32; k++) stream_q.push_back(8'(8'h40 + k));
      expect_stream();
      send_chunk(128'h4F4E4D4C4B4A49484746454443424140, 16, 1, 0);
      send_chunk(128'h5F5E5D5C5B5A59585756555453525150, 16, 1, 0);
      @(negedge clk);
      chk("bp_fill", 64'(fillLevel), 64'd32);
      chk("bp_csShift", 64'(csShift), 64'd0);
      repeat (4) @(negedge clk);
      chk("bp_fill_hold", 64'(fillLevel), 64'd32);
      chk("bp_tvalid", 64'(tvalid), 64'd1);
      @(posedge clk); #1;
      mode = 0;
      send_chunk('0, 0, 0, 1);
      wait_drain("drain_t3");

      // Toggling tready with mixed chunk sizes
      mode = 2;
      stream_q.delete();
      for (int k = 0; k < 82; k++) stream_q.push_back(8'(k * 37 + 11));
      expect_stream();
      off = 0;
      for (int j = 0; j < 10; j++) begin
         d = '0;
         for (int k = 0; k < sizes[j]; k++) d[k*8 +: 8] = 8'((off + k) * 37 + 11);
         send_chunk(d, sizes[j], 1, j == 9);
         off += sizes[j];
      end
      wait_drain("drain_t4");

      // Zero-byte chunks, then EOS yields one null beat
      mode = 0;
      for (int j = 0; j < 5; j++) send_chunk(128'hDEADBEEF, 0, 1, 0);
      @(negedge clk);
      chk("zero_fill", 64'(fillLevel), 64'd0);
      chk("zero_tvalid", 64'(tvalid), 64'd0);
      @(posedge clk); #1;
      exp_q.push_back('{d: 64'h0, s: 8'h00, l: 1'b1});
      send_chunk('0, 0, 0, 1);
      wait_drain("drain_t5");

      // Asynchronous reset while a 5-byte final beat is pending
      mode = 1;
      @(posedge clk); #1;
      send_chunk(128'h0505050505, 5, 1, 1);
      @(negedge clk);
      chk("pre_rst_fill", 64'(fillLevel), 64'd5);
      chk("pre_rst_tlast", 64'(tlast), 64'd1);
      #2 rst_n = 0;
      #1;
      chk("arst_tvalid", 64'(tvalid), 64'd0);
      chk("arst_fill", 64'(fillLevel), 64'd0);
      chk("arst_csShift", 64'(csShift), 64'd1);
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1;
      mode = 0;
      exp_q.push_back('{d: 64'h0000000000A3A2A1, s: 8'h07, l: 1'b1});
      send_chunk(128'hA3A2A1, 3, 1, 1);
      wait_drain("drain_t6");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
